// File: rtl/event_decoder_level_0_pkg.sv
// Shared types and constants for the level-0 event decoder.
package event_decoder_level_0_pkg;

  localparam int DIM            = 4;
  localparam int ADDR_W         = 2;
  localparam int EV_W           = 2 * ADDR_W;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK_WAIT = 2'd2
  } state_t;

  // Pixel grid, indexed [row][col]
  typedef logic [DIM-1:0][DIM-1:0] grid_t;

  // One-hot grid with a single bit set at [row][col]
  function automatic grid_t grid_onehot(input logic [ADDR_W-1:0] row,
                                        input logic [ADDR_W-1:0] col);
    grid_t g;
    g           = '0;
    g[row][col] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/event_decoder_level_0_if.sv
// Arbiter handshake and buffered event stream of the level-0 decoder.
interface event_decoder_level_0_if;
  import event_decoder_level_0_pkg::*;

  logic              req_i;
  logic [ADDR_W-1:0] x_add_i;
  logic [ADDR_W-1:0] y_add_i;
  logic              ack_o;
  logic              ev_valid_o;
  logic              ev_ready_i;
  logic [ADDR_W-1:0] ev_x_o;
  logic [ADDR_W-1:0] ev_y_o;

  // Decoder side
  modport slave (
    input  req_i, x_add_i, y_add_i, ev_ready_i,
    output ack_o, ev_valid_o, ev_x_o, ev_y_o
  );

  // Arbiter / event consumer side
  modport master (
    output req_i, x_add_i, y_add_i, ev_ready_i,
    input  ack_o, ev_valid_o, ev_x_o, ev_y_o
  );

endinterface

// File: rtl/event_decoder_level_0_event_fifo.sv
// Synchronous FIFO; push is honoured when full if a pop happens in the same cycle.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (r_count == (PTR_W + 1)'(0));
  assign full_o    = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  // Head entry is masked to zero when empty so outputs read zero after reset
  assign data_o    = empty_o ? {WIDTH{1'b0}} : r_mem[r_rptr];

  // Storage write; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointers (depth is a power of two, so they wrap naturally) and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      else           r_wptr <= r_wptr;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      else           r_rptr <= r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/event_decoder_level_0.sv
// Level-0 event decoder: 4-phase arbiter handshake, pixel clear, frame bitmap,
// buffered event stream and saturating event counter.
module event_decoder_level_0
  import event_decoder_level_0_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  event_decoder_level_0_if.slave        bus,
  output grid_t                         clr_o,
  output grid_t                         frame_o,
  input  logic                          frame_rd_i,
  output logic                          fifo_full_o,
  output logic [7:0]                    ev_count_o
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_hold_x;
  logic [ADDR_W-1:0] r_hold_y;
  logic              r_ack;
  grid_t             r_clr;
  grid_t             r_frame;
  logic [7:0]        r_count;
  logic              w_accept;
  logic              w_capture;
  logic              w_ack_nxt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [EV_W-1:0]   w_fifo_dout;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a request is only taken when the buffer has room
  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE: begin
        if (bus.req_i && !w_fifo_full) w_state_nxt = CAPTURE;
        else                           w_state_nxt = IDLE;
      end
      CAPTURE: begin
        w_state_nxt = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (bus.req_i) w_state_nxt = ACK_WAIT;
        else           w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode: accept strobe, capture strobe and next acknowledge value
  always_comb begin
    w_accept  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE:     w_accept  = (w_state_nxt == CAPTURE);
      CAPTURE:  w_capture = 1'b1;
      ACK_WAIT: w_capture = 1'b0;
      default:  w_capture = 1'b0;
    endcase
    w_ack_nxt = (w_state_nxt == ACK_WAIT);
  end

  // Holding register, registered ack and one-cycle clear pulse aligned with CAPTURE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hold_x <= '0;
      r_hold_y <= '0;
      r_ack    <= 1'b0;
      r_clr    <= '0;
    end else begin
      r_ack <= w_ack_nxt;
      if (w_accept) begin
        r_hold_x <= bus.x_add_i;
        r_hold_y <= bus.y_add_i;
        r_clr    <= grid_onehot(bus.x_add_i, bus.y_add_i);
      end else begin
        r_hold_x <= r_hold_x;
        r_hold_y <= r_hold_y;
        r_clr    <= '0;
      end
    end
  end

  // Frame bitmap; a capture in the same cycle as a read survives the clear
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_frame <= '0;
    end else begin
      r_frame <= (frame_rd_i ? grid_t'('0) : r_frame) |
                 (w_capture ? grid_onehot(r_hold_x, r_hold_y) : grid_t'('0));
    end
  end

  // Saturating accepted-event counter
  always_ff @(posedge clk_i) begin
    if (reset_i)                                 r_count <= 8'd0;
    else if (w_capture && (r_count != 8'd255))   r_count <= r_count + 8'd1;
    else                                         r_count <= r_count;
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (w_capture),
    .pop_i   (bus.ev_ready_i),
    .data_i  ({r_hold_x, r_hold_y}),
    .data_o  (w_fifo_dout),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign bus.ack_o      = r_ack;
  assign bus.ev_valid_o = ~w_fifo_empty;
  assign bus.ev_x_o     = w_fifo_dout[EV_W-1:ADDR_W];
  assign bus.ev_y_o     = w_fifo_dout[ADDR_W-1:0];
  assign clr_o          = r_clr;
  assign frame_o        = r_frame;
  assign fifo_full_o    = w_fifo_full;
  assign ev_count_o     = r_count;

endmodule

// File: tb/tb_event_decoder_level_0.sv
// Scoreboard bench for event_decoder_level_0: directed handshakes, expected
// events queued at issue time and checked by an independent stream monitor.
module tb_event_decoder_level_0;
  import event_decoder_level_0_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       frame_rd_i;
  grid_t      clr_o;
  grid_t      frame_o;
  logic       fifo_full_o;
  logic [7:0] ev_count_o;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q [$];

  event_decoder_level_0_if bus ();

  event_decoder_level_0 #(.FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .bus         (bus),
    .clr_o       (clr_o),
    .frame_o     (frame_o),
    .frame_rd_i  (frame_rd_i),
    .fifo_full_o (fifo_full_o),
    .ev_count_o  (ev_count_o)
  );

  // Clock generation
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Stream monitor: a pop happens at the next rising edge whenever valid & ready
  always @(negedge clk_i) begin
    if (!reset_i && bus.ev_valid_o && bus.ev_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {28'd0, bus.ev_x_o, bus.ev_y_o}, 32'hFFFF_FFFF);
      end else begin
        chk("event_order", {28'd0, bus.ev_x_o, bus.ev_y_o}, {28'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ack();
    int n = 0;
    while (!bus.ack_o && n < 100) begin
      tick();
      n++;
    end
    chk("ack_timeout", {31'd0, bus.ack_o}, 32'd1);
  endtask

  task automatic wait_capture();
    int n = 0;
    while (clr_o == 16'h0000 && n < 100) begin
      tick();
      n++;
    end
    chk("capture_timeout", {31'd0, (clr_o != 16'h0000)}, 32'd1);
  endtask

  task automatic send(input logic [1:0] x, input logic [1:0] y);
    bus.req_i   = 1'b1;
    bus.x_add_i = x;
    bus.y_add_i = y;
    wait_ack();
    exp_q.push_back({x, y});
    bus.req_i = 1'b0;
    tick();
    chk("ack_release", {31'd0, bus.ack_o}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    bus.ev_ready_i = 1'b1;
    while (bus.ev_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", {31'd0, bus.ev_valid_o}, 32'd0);
    bus.ev_ready_i = 1'b0;
  endtask

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    bus.req_i      = 1'b0;
    bus.x_add_i    = 2'd0;
    bus.y_add_i    = 2'd0;
    bus.ev_ready_i = 1'b0;
    frame_rd_i     = 1'b0;
    reset_i        = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_ack",   {31'd0, bus.ack_o},       32'd0);
    chk("rst_clr",   {16'd0, clr_o},           32'd0);
    chk("rst_frame", {16'd0, frame_o},         32'd0);
    chk("rst_valid", {31'd0, bus.ev_valid_o},  32'd0);
    chk("rst_full",  {31'd0, fifo_full_o},     32'd0);
    chk("rst_evxy",  {28'd0, bus.ev_x_o, bus.ev_y_o}, 32'd0);
    chk("rst_count", {24'd0, ev_count_o},      32'd0);

    // Single event at (2,1); address change after acceptance is ignored
    bus.req_i   = 1'b1;
    bus.x_add_i = 2'd2;
    bus.y_add_i = 2'd1;
    tick();
    chk("se_clr_pulse",  {16'd0, clr_o}, 32'h0000_0200);
    chk("se_ack_capt",   {31'd0, bus.ack_o}, 32'd0);
    bus.x_add_i = 2'd3;
    bus.y_add_i = 2'd3;
    tick();
    chk("se_clr_end",    {16'd0, clr_o}, 32'd0);
    chk("se_ack_high",   {31'd0, bus.ack_o}, 32'd1);
    chk("se_frame",      {16'd0, frame_o}, 32'h0000_0200);
    chk("se_valid",      {31'd0, bus.ev_valid_o}, 32'd1);
    chk("se_evxy",       {28'd0, bus.ev_x_o, bus.ev_y_o}, 32'h9);
    chk("se_count",      {24'd0, ev_count_o}, 32'd1);
    exp_q.push_back(4'b1001);
    tick();
    chk("se_ack_hold",   {31'd0, bus.ack_o}, 32'd1);
    bus.req_i = 1'b0;
    tick();
    chk("se_ack_drop",   {31'd0, bus.ack_o}, 32'd0);
    drain();

    // Back-pressure: fill, 5th request held, one pop lets it in
    send(2'd0, 2'd0);
    send(2'd1, 2'd1);
    send(2'd2, 2'd2);
    send(2'd3, 2'd3);
    chk("bp_full", {31'd0, fifo_full_o}, 32'd1);
    bus.req_i   = 1'b1;
    bus.x_add_i = 2'd0;
    bus.y_add_i = 2'd1;
    repeat (5) tick();
    chk("bp_no_ack", {31'd0, bus.ack_o}, 32'd0);
    chk("bp_no_clr", {16'd0, clr_o}, 32'd0);
    bus.ev_ready_i = 1'b1;
    tick();
    bus.ev_ready_i = 1'b0;
    chk("bp_not_full", {31'd0, fifo_full_o}, 32'd0);
    send(2'd0, 2'd1);
    chk("bp_full_again", {31'd0, fifo_full_o}, 32'd1);
    drain();

    // Push and pop in the same cycle keep occupancy unchanged
    send(2'd1, 2'd0);
    send(2'd2, 2'd1);
    send(2'd3, 2'd2);
    bus.req_i   = 1'b1;
    bus.x_add_i = 2'd0;
    bus.y_add_i = 2'd2;
    wait_capture();
    bus.ev_ready_i = 1'b1;
    tick();
    bus.ev_ready_i = 1'b0;
    chk("pp_full", {31'd0, fifo_full_o}, 32'd0);
    chk("pp_ack",  {31'd0, bus.ack_o},   32'd1);
    exp_q.push_back(4'b0010);
    bus.req_i = 1'b0;
    tick();
    send(2'd1, 2'd3);
    chk("pp_full_at4", {31'd0, fifo_full_o}, 32'd1);
    drain();

    // Frame read colliding with a capture
    frame_rd_i = 1'b1;
    tick();
    frame_rd_i = 1'b0;
    chk("fr_cleared", {16'd0, frame_o}, 32'd0);
    send(2'd0, 2'd3);
    chk("fr_bit03", {16'd0, frame_o}, 32'h0000_0008);
    bus.req_i   = 1'b1;
    bus.x_add_i = 2'd1;
    bus.y_add_i = 2'd2;
    wait_capture();
    frame_rd_i = 1'b1;
    tick();
    frame_rd_i = 1'b0;
    chk("fr_collide", {16'd0, frame_o}, 32'h0000_0040);
    exp_q.push_back(4'b0110);
    bus.req_i = 1'b0;
    tick();
    drain();

    // Repeated events at one pixel
    frame_rd_i = 1'b1;
    tick();
    frame_rd_i = 1'b0;
    send(2'd2, 2'd2);
    send(2'd2, 2'd2);
    chk("rep_frame", {16'd0, frame_o}, 32'h0000_0400);
    drain();

    // Counter saturation
    bus.ev_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(2'(i >> 2), 2'(i));
    end
    drain();
    chk("sat_count", {24'd0, ev_count_o}, 32'd255);

    // Reset while in ACK_WAIT with req held high
    bus.req_i   = 1'b1;
    bus.x_add_i = 2'd3;
    bus.y_add_i = 2'd1;
    wait_ack();
    reset_i = 1'b1;
    tick();
    exp_q.delete();
    chk("mr_ack",   {31'd0, bus.ack_o},      32'd0);
    chk("mr_clr",   {16'd0, clr_o},          32'd0);
    chk("mr_frame", {16'd0, frame_o},        32'd0);
    chk("mr_valid", {31'd0, bus.ev_valid_o}, 32'd0);
    chk("mr_full",  {31'd0, fifo_full_o},    32'd0);
    chk("mr_evxy",  {28'd0, bus.ev_x_o, bus.ev_y_o}, 32'd0);
    chk("mr_count", {24'd0, ev_count_o},     32'd0);
    reset_i = 1'b0;
    tick();
    chk("mr_new_clr", {16'd0, clr_o}, 32'h0000_2000);
    chk("mr_new_ack0", {31'd0, bus.ack_o}, 32'd0);
    tick();
    chk("mr_new_ack1", {31'd0, bus.ack_o}, 32'd1);
    exp_q.push_back(4'b1101);
    bus.req_i = 1'b0;
    tick();
    chk("mr_ack_drop", {31'd0, bus.ack_o}, 32'd0);
    chk("mr_count1",   {24'd0, ev_count_o}, 32'd1);
    drain();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
